// File: rtl/shift_pkg.sv
// Shared types and constants for the register-amount shift sequencer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents:
//   SH_WIDTH    - default operand/result width
//   SH_AMT_W    - default shift-amount width (bottom byte of a register)
//   shtype_e    - shift type, same encoding as instr[1:0]
//   seq_state_e - sequencer FSM states
package shift_pkg;

    localparam int SH_WIDTH = 32;
    localparam int SH_AMT_W = 8;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shtype_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } seq_state_e;

endpackage : shift_pkg

// File: rtl/shift_step1.sv
// Single-bit shift step for LSL/LSR/ASR/ROR with the bit shifted out as carry.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   i_value [WIDTH-1:0] - value before the step
//   i_type  [1:0]       - shift type (shtype_e encoding)
//   o_value [WIDTH-1:0] - value after one 1-bit step
//   o_carry             - bit shifted out by this step
module shift_step1
    import shift_pkg::*;
#(
    parameter int WIDTH = SH_WIDTH
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic [1:0]       i_type,
    output logic [WIDTH-1:0] o_value,
    output logic             o_carry
);

    always_comb begin
        o_value = i_value;
        o_carry = 1'b0;
        case (shtype_e'(i_type))
            SH_LSL: begin
                o_carry = i_value[WIDTH-1];
                o_value = {i_value[WIDTH-2:0], 1'b0};
            end
            SH_LSR: begin
                o_carry = i_value[0];
                o_value = {1'b0, i_value[WIDTH-1:1]};
            end
            SH_ASR: begin
                // Sign bit is replicated into the vacated MSB.
                o_carry = i_value[0];
                o_value = {i_value[WIDTH-1], i_value[WIDTH-1:1]};
            end
            SH_ROR: begin
                o_carry = i_value[0];
                o_value = {i_value[0], i_value[WIDTH-1:1]};
            end
            default: begin
                o_value = i_value;
                o_carry = 1'b0;
            end
        endcase
    end

endmodule : shift_step1

// File: rtl/shift_seq.sv
// Multi-cycle LSL/LSR/ASR/ROR by a register amount, ARM carry-out semantics.
// Latency: one edge per 1-bit step (up to WIDTH+1); zero-step commands land in DONE on the accept edge.
// Backpressure: command accepted only in IDLE; result held in DONE until res_ready.
//
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   start_valid/ready    - command handshake (ready only in IDLE)
//   op_a, sh_type,
//   sh_amt, carry_in     - command fields, sampled only at accept
//   res_valid/ready      - result handshake (valid only in DONE)
//   result, carry_out    - shifted value and shifter carry
//   busy                 - sequencer not idle
module shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = SH_WIDTH,
    parameter int AMT_W = SH_AMT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [1:0]       sh_type,
    input  logic [AMT_W-1:0] sh_amt,
    input  logic             carry_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             busy
);

    // Counter must hold WIDTH+1: the extra LSL/LSR step past WIDTH flushes
    // the carry to zero for amounts larger than the operand.
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam int LOG_W = $clog2(WIDTH);

    localparam logic [AMT_W-1:0] LSX_MAX = AMT_W'(WIDTH + 1);
    localparam logic [AMT_W-1:0] ASR_MAX = AMT_W'(WIDTH);

    seq_state_e       r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_type;
    logic             r_res_valid;

    logic [CNT_W-1:0] w_cnt_load;
    logic             w_carry_load;
    logic [LOG_W-1:0] w_ror_amt;
    logic [WIDTH-1:0] w_step_value;
    logic             w_step_carry;
    logic             w_accept;

    assign start_ready = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign res_valid   = r_res_valid;
    assign result      = r_result;
    assign carry_out   = r_carry;

    assign w_accept  = start_valid && (r_state == S_IDLE);
    assign w_ror_amt = sh_amt[LOG_W-1:0];

    // Step count and initial carry chosen at accept time.
    always_comb begin
        w_cnt_load   = '0;
        w_carry_load = carry_in;
        if (sh_amt != '0) begin
            case (shtype_e'(sh_type))
                SH_LSL, SH_LSR: begin
                    if (sh_amt > LSX_MAX) begin
                        w_cnt_load = CNT_W'(WIDTH + 1);
                    end else begin
                        w_cnt_load = CNT_W'(sh_amt);
                    end
                end
                SH_ASR: begin
                    // Beyond WIDTH every step is identical (all sign bits).
                    if (sh_amt > ASR_MAX) begin
                        w_cnt_load = CNT_W'(WIDTH);
                    end else begin
                        w_cnt_load = CNT_W'(sh_amt);
                    end
                end
                SH_ROR: begin
                    // Rotation is modulo WIDTH; a nonzero multiple of WIDTH
                    // leaves the value untouched but still reports the MSB.
                    if (w_ror_amt != '0) begin
                        w_cnt_load = CNT_W'(w_ror_amt);
                    end else begin
                        w_carry_load = op_a[WIDTH-1];
                    end
                end
                default: begin
                    w_cnt_load   = '0;
                    w_carry_load = carry_in;
                end
            endcase
        end
    end

    shift_step1 #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_value (r_result),
        .i_type  (r_type),
        .o_value (w_step_value),
        .o_carry (w_step_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_type      <= 2'b00;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_result <= op_a;
                        r_type   <= sh_type;
                        r_carry  <= w_carry_load;
                        r_cnt    <= w_cnt_load;
                        if (w_cnt_load == '0) begin
                            r_state     <= S_DONE;
                            r_res_valid <= 1'b1;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_result <= w_step_value;
                    r_carry  <= w_step_carry;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state     <= S_DONE;
                        r_res_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state     <= S_IDLE;
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : shift_seq

// File: tb/tb_shift_seq.sv
module tb_shift_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] op_a;
    logic [1:0]  sh_type;
    logic [7:0]  sh_amt;
    logic        carry_in;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] result;
    logic        carry_out;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_seq #(.WIDTH(32), .AMT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .sh_type     (sh_type),
        .sh_amt      (sh_amt),
        .carry_in    (carry_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .carry_out   (carry_out),
        .busy        (busy)
    );

    typedef struct {
        logic [31:0] op;
        logic [1:0]  typ;
        logic [7:0]  amt;
        logic        cin;
        logic [31:0] exp_res;
        logic        exp_c;
        int          exp_lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic on a 64-bit extension; the carry is
    // simply the last bit that fell off the 32-bit window.
    function automatic void model(input logic [31:0] op, input logic [1:0] t,
                                  input logic [7:0] amt, input logic cin,
                                  output logic [31:0] r, output logic c, output int lat);
        logic [63:0] e;
        int k;
        r = op; c = cin; lat = 0;
        if (amt != 0) begin
            case (t)
                2'd0: begin
                    e = {32'b0, op} << amt;
                    r = e[31:0]; c = e[32];
                    lat = (amt > 33) ? 33 : int'(amt);
                end
                2'd1: begin
                    e = {op, 32'b0} >> amt;
                    r = e[63:32]; c = e[31];
                    lat = (amt > 33) ? 33 : int'(amt);
                end
                2'd2: begin
                    e = $unsigned($signed({op, 32'b0}) >>> amt);
                    r = e[63:32]; c = e[31];
                    lat = (amt > 32) ? 32 : int'(amt);
                end
                default: begin
                    k = int'(amt) % 32;
                    if (k == 0) begin
                        r = op; c = op[31]; lat = 0;
                    end else begin
                        r = (op >> k) | (op << (32 - k));
                        c = r[31]; lat = k;
                    end
                end
            endcase
        end
    endfunction

    function automatic vec_t mk(input logic [31:0] op, input logic [1:0] t, input logic [7:0] amt,
                                input logic cin, input logic [31:0] er, input logic ec, input int el);
        vec_t v;
        v.op = op; v.typ = t; v.amt = amt; v.cin = cin;
        v.exp_res = er; v.exp_c = ec; v.exp_lat = el;
        return v;
    endfunction

    // Issue one command and complete it. Latency is counted in rising edges
    // after the accept edge until res_valid is seen (0 = valid straight off
    // the accept edge). hold>0 keeps res_ready low that many cycles in DONE
    // and pulses start_valid meanwhile, which must be ignored.
    task automatic run_cmd(input string name, input logic [31:0] op, input logic [1:0] t,
                           input logic [7:0] amt, input logic cin,
                           input logic [31:0] er, input logic ec, input int el, input int hold);
        int lat;
        bit bad_busy;
        @(negedge clk);
        chk({name, " start_ready idle"}, 64'(start_ready), 64'd1);
        start_valid = 1'b1; op_a = op; sh_type = t; sh_amt = amt; carry_in = cin;
        @(negedge clk);
        start_valid = 1'b0;
        op_a = $urandom; sh_type = 2'($urandom); sh_amt = 8'($urandom); carry_in = 1'($urandom);
        lat = 0; bad_busy = 0;
        while (!res_valid && lat < 100) begin
            if (busy !== 1'b1 || start_ready !== 1'b0) bad_busy = 1;
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) begin
            checks++; failures++;
            $display("FAIL %s timeout: res_valid never rose within 100 cycles", name);
        end else begin
            chk({name, " latency"}, 64'(lat), 64'(el));
            chk({name, " busy/ready while shifting"}, 64'(bad_busy), 64'd0);
            chk({name, " result"}, 64'(result), 64'(er));
            chk({name, " carry"}, 64'(carry_out), 64'(ec));
            chk({name, " busy in done"}, 64'(busy), 64'd1);
            for (int h = 0; h < hold; h++) begin
                start_valid = (h == 1);
                @(negedge clk);
                chk({name, " hold valid"}, 64'(res_valid), 64'd1);
                chk({name, " hold result"}, {31'b0, carry_out, result}, {31'b0, ec, er});
                chk({name, " hold start_ready"}, 64'(start_ready), 64'd0);
            end
            start_valid = 1'b0;
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            chk({name, " valid drops"}, 64'(res_valid), 64'd0);
            chk({name, " idle after handshake"}, {62'b0, busy, start_ready}, 64'b01);
        end
    endtask

    initial begin
        reset = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
        op_a = '0; sh_type = '0; sh_amt = '0; carry_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outputs", {28'b0, res_valid, busy, carry_out, 1'b0, result}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("start_ready after reset", 64'(start_ready), 64'd1);

        vecs[0]  = mk(32'h8000_0001, 2'd0, 8'd1,   1'b0, 32'h0000_0002, 1'b1, 1);
        vecs[1]  = mk(32'h8000_0000, 2'd2, 8'd40,  1'b0, 32'hFFFF_FFFF, 1'b1, 32);
        vecs[2]  = mk(32'hFFFF_FFFF, 2'd1, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 32);
        vecs[3]  = mk(32'hFFFF_FFFF, 2'd1, 8'd33,  1'b1, 32'h0000_0000, 1'b0, 33);
        vecs[4]  = mk(32'h0000_0001, 2'd0, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 32);
        vecs[5]  = mk(32'h0000_00F1, 2'd3, 8'd4,   1'b1, 32'h1000_000F, 1'b0, 4);
        vecs[6]  = mk(32'h8000_0000, 2'd3, 8'd32,  1'b0, 32'h8000_0000, 1'b1, 0);
        vecs[7]  = mk(32'h1234_5678, 2'd0, 8'd0,   1'b1, 32'h1234_5678, 1'b1, 0);
        vecs[8]  = mk(32'h1234_5678, 2'd1, 8'd0,   1'b1, 32'h1234_5678, 1'b1, 0);
        vecs[9]  = mk(32'h1234_5678, 2'd2, 8'd0,   1'b1, 32'h1234_5678, 1'b1, 0);
        vecs[10] = mk(32'h1234_5678, 2'd3, 8'd0,   1'b1, 32'h1234_5678, 1'b1, 0);
        vecs[11] = mk(32'h0000_0001, 2'd0, 8'd200, 1'b1, 32'h0000_0000, 1'b0, 33);
        vecs[12] = mk(32'h7FFF_FFFF, 2'd2, 8'd255, 1'b1, 32'h0000_0000, 1'b0, 32);
        vecs[13] = mk(32'h0000_0003, 2'd3, 8'd33,  1'b0, 32'h8000_0001, 1'b1, 1);
        vecs[14] = mk(32'h4000_0000, 2'd3, 8'd64,  1'b1, 32'h4000_0000, 1'b0, 0);
        vecs[15] = mk(32'hF000_0000, 2'd2, 8'd4,   1'b0, 32'hFF00_0000, 1'b0, 4);

        for (int i = 0; i < 16; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].typ, vecs[i].amt, vecs[i].cin,
                    vecs[i].exp_res, vecs[i].exp_c, vecs[i].exp_lat, 0);
        end

        // Back-pressure: 5 cycles in DONE with an ignored start_valid pulse.
        run_cmd("backpressure", 32'hA5A5_0F0F, 2'd1, 8'd3, 1'b0, 32'h14B4_A1E1, 1'b1, 3, 5);

        // Reset in the middle of a long LSL.
        @(negedge clk);
        start_valid = 1'b1; op_a = 32'hDEAD_BEEF; sh_type = 2'd0; sh_amt = 8'd20; carry_in = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("midshift busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midshift reset state",
            {28'b0, res_valid, busy, carry_out, start_ready, result}, {28'b0, 4'b0001, 32'h0});
        run_cmd("after reset", 32'h0000_0001, 2'd0, 8'd3, 1'b0, 32'h0000_0008, 1'b0, 3, 0);

        // Randomized commands against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] rop, er;
            logic [1:0]  rt;
            logic [7:0]  ra;
            logic        rc, ec;
            int          el;
            rop = $urandom;
            rt  = 2'($urandom);
            ra  = (n % 2 == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom);
            rc  = 1'($urandom);
            model(rop, rt, ra, rc, er, ec, el);
            run_cmd($sformatf("rand%0d", n), rop, rt, ra, rc, er, ec, el, (n % 7 == 0) ? 2 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_shift_seq
